// File: rtl/spi_m_trx.sv
// spi_m_trx: SPI master transceiver with per-word handshake and CS-held bursts
module spi_m_trx #(
  parameter int   DATA_W     = 8,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   MAX_COUNT  = 4,
  parameter int   COUNT_BITS = 12,
  parameter logic LSB_FIRST  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_data_valid,
  input  logic              i_tx_last,
  output logic              o_tx_ready,
  input  logic              i_spi_rx,
  output logic              o_spi_tx,
  output logic              o_spi_clk,
  output logic              o_spi_cs_n,
  output logic              o_spi_busy,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_data_valid
);
  localparam int HP_W = $clog2(2 * DATA_W + 1);
  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, HOLD, GAP} state_t;
  state_t st, ns;
  logic [COUNT_BITS-1:0] cnt;
  logic [HP_W-1:0] hp;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_d;
  logic last_q, rx_done, acc, tick, edge_ev, shift_ev, samp_ev, fin_samp;
  logic sck_d, cs_d, mosi_d, busy_d, ready_d;
  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] x);
    return LSB_FIRST ? x >> 1 : x << 1;
  endfunction
  function automatic logic head(input logic [DATA_W-1:0] x);
    return LSB_FIRST ? x[0] : x[DATA_W-1];
  endfunction
  assign acc      = i_tx_data_valid && o_tx_ready;
  assign tick     = cnt == COUNT_BITS'(MAX_COUNT - 1);
  assign edge_ev  = st == XFER && tick && hp != HP_W'(2 * DATA_W);
  assign shift_ev = edge_ev && (hp[0] ^ CPHA);
  assign samp_ev  = edge_ev && !(hp[0] ^ CPHA);
  assign fin_samp = samp_ev && hp == HP_W'(2 * DATA_W - (CPHA ? 1 : 2));
  // state register with half-period timer and SCK half-period index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      hp  <= '0;
    end else begin
      st  <= ns;
      cnt <= (ns != st || tick) ? '0 : cnt + 1'b1;
      hp  <= (st == XFER && ns == XFER) ? hp + HP_W'(tick) : '0;
    end
  end
  // next-state: XFER spans 2*DATA_W edges plus a closing half-period at CPOL
  always_comb begin
    ns = st;
    case (st)
      IDLE:    ns = acc ? LEAD : IDLE;
      LEAD:    ns = tick ? XFER : LEAD;
      XFER:    ns = (tick && hp == HP_W'(2 * DATA_W)) ? TRAIL : XFER;
      TRAIL:   ns = tick ? (last_q ? GAP : HOLD) : TRAIL;
      HOLD:    ns = acc ? XFER : HOLD;
      GAP:     ns = tick ? IDLE : GAP;
      default: ns = IDLE;
    endcase
  end
  // next values of the registered outputs, derived from the upcoming state
  always_comb begin
    cs_d      = ns == IDLE || ns == GAP;
    busy_d    = ns != IDLE;
    ready_d   = ns == IDLE || ns == HOLD;
    sck_d     = ns == XFER ? o_spi_clk ^ edge_ev : CPOL;
    mosi_d    = cs_d ? 1'b0 : acc ? (CPHA ? 1'b0 : head(i_tx_data)) : shift_ev ? head(tx_sr) : o_spi_tx;
    rx_data_d = rx_done ? rx_sr : o_rx_data;
  end
  // output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_spi_clk       <= CPOL;
      o_spi_cs_n      <= 1'b1;
      o_spi_tx        <= 1'b0;
      o_spi_busy      <= 1'b0;
      o_tx_ready      <= 1'b1;
      o_rx_data       <= '0;
      o_rx_data_valid <= 1'b0;
    end else begin
      o_spi_clk       <= sck_d;
      o_spi_cs_n      <= cs_d;
      o_spi_tx        <= mosi_d;
      o_spi_busy      <= busy_d;
      o_tx_ready      <= ready_d;
      o_rx_data       <= rx_data_d;
      o_rx_data_valid <= rx_done;
    end
  end
  // shift registers; CPHA=0 preloads with the first bit already on MOSI
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      last_q  <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      if (acc) begin
        tx_sr  <= CPHA ? i_tx_data : adv(i_tx_data);
        last_q <= i_tx_last;
      end else if (shift_ev) begin
        tx_sr <= adv(tx_sr);
      end
      if (samp_ev) rx_sr <= LSB_FIRST ? {i_spi_rx, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], i_spi_rx};
      rx_done <= fin_samp;
    end
  end
endmodule
